// File: rtl/counter_pkg.sv
// Shared types and constants for the parameterised up/down counter.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } count_mode_e;

  localparam int CNT_DEF_WIDTH = 8;

endpackage

// File: rtl/counter_next_val.sv
// Next-state datapath: load/inc/dec priority, boundary handling and flag set strobes.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int               WIDTH = CNT_DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_Q = '1,
  parameter count_mode_e      MODE  = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q_nxt,
  output logic             ovf_set,
  output logic             unf_set
);

  always_comb begin
    q_nxt   = q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ld) begin
      q_nxt = (data_in > MAX_Q) ? MAX_Q : data_in;
    end else if (inc && dec) begin
      q_nxt = q;
    end else if (inc) begin
      if (q == MAX_Q) begin
        ovf_set = 1'b1;
        q_nxt   = (MODE == CNT_SAT) ? MAX_Q : '0;
      end else begin
        q_nxt = q + WIDTH'(1);
      end
    end else if (dec) begin
      if (q == '0) begin
        unf_set = 1'b1;
        q_nxt   = (MODE == CNT_SAT) ? '0 : MAX_Q;
      end else begin
        q_nxt = q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/param_counter.sv
// Modulo/saturating up-down counter with sticky overflow/underflow flags.
module param_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = CNT_DEF_WIDTH,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter count_mode_e     MODE    = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_zero,
  output logic             ovf,
  output logic             unf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_counter: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "param_counter: MAX_VAL=%0d outside 1..2**WIDTH-1", MAX_VAL);
  end

  localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_d, q_q;
  logic             ovf_d, ovf_q, unf_d, unf_q;
  logic             ovf_set, unf_set;

  counter_next_val #(
    .WIDTH (WIDTH),
    .MAX_Q (MAX_Q),
    .MODE  (MODE)
  ) u_next (
    .q       (q_q),
    .ld      (ld),
    .inc     (inc),
    .dec     (dec),
    .data_in (data_in),
    .q_nxt   (q_d),
    .ovf_set (ovf_set),
    .unf_set (unf_set)
  );

  // A set event in the same cycle as clr_flags must win.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~clr_flags);
    unf_d = unf_set | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q       = q_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign at_max  = (q_q == MAX_Q);
  assign at_zero = (q_q == '0);

endmodule
